count_sequencer: RTL

- Controller that sequences an 8-bit up-counter datapath: start/abort/pause control, programmable prescaler, terminal-count compare, one-shot or periodic operation.
- Sits between ui_in control pins and the uo_out count display in the top-level user design.
- Replaces the free-running enable-only counting with a run-to-limit timer. It raises a done strobe at the terminal count.

---
 rtl/count_seq_pkg.sv | 14 +
 rtl/count_seq_core.sv | 56 +++++
 rtl/count_sequencer.sv | 134 +++++++++++++
 3 files changed

// File: rtl/count_seq_pkg.sv
// Shared state encodings and default widths for the count sequencer.
package count_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int CNT_W_DEF = 8;
    localparam int PRE_W_DEF = 4;

endpackage

// File: rtl/count_seq_core.sv
// Prescaler plus up-counter datapath with latched prescale/limit,
// clear/enable/wrap controls and a terminal-count match output.
module count_seq_core #(
    parameter int CNT_W = 8,
    parameter int PRE_W = 4
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_load,
    input  logic             i_clear,
    input  logic             i_enable,
    input  logic             i_wrap,
    input  logic [PRE_W-1:0] i_prescale,
    input  logic [CNT_W-1:0] i_limit,
    output logic [CNT_W-1:0] o_count,
    output logic             o_step,
    output logic             o_term
);

    logic [PRE_W-1:0] r_pre;
    logic [PRE_W-1:0] r_pre_val;
    logic [CNT_W-1:0] r_limit;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_inc;

    assign w_count_inc = r_count + CNT_W'(1);
    assign o_step      = (r_pre == r_pre_val);
    // Terminal match is only meaningful on the edge that actually steps the count.
    assign o_term      = o_step && (w_count_inc == r_limit);
    assign o_count     = r_count;

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_pre     <= '0;
            r_pre_val <= '0;
            r_limit   <= '0;
            r_count   <= '0;
        end else if (i_load) begin
            r_pre_val <= i_prescale;
            r_limit   <= i_limit;
            r_pre     <= '0;
            r_count   <= '0;
        end else if (i_clear) begin
            r_pre     <= '0;
            r_count   <= '0;
        end else if (i_enable) begin
            if (o_step) begin
                r_pre   <= '0;
                r_count <= (o_term && i_wrap) ? '0 : w_count_inc;
            end else begin
                r_pre   <= r_pre + PRE_W'(1);
            end
        end
    end

endmodule

// File: rtl/count_sequencer.sv
// Run-to-limit timer controller: start/abort/pause sequencing around count_seq_core.
//   state | meaning
//   IDLE  | waiting for start, count cleared
//   RUN   | prescaler and counter advancing
//   PAUSE | run frozen while i_pause is high
//   DONE  | one-shot finished, count holds L
module count_sequencer
    import count_seq_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int PRE_W = PRE_W_DEF
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_start,
    input  logic             i_abort,
    input  logic             i_pause,
    input  logic             i_periodic,
    input  logic [PRE_W-1:0] i_prescale,
    input  logic [CNT_W-1:0] i_limit,
    output logic [CNT_W-1:0] o_count,
    output logic             o_busy,
    output logic             o_tick,
    output logic             o_done,
    output logic             o_err,
    output logic [1:0]       o_state
);

    state_t r_state;
    logic   r_busy;
    logic   r_tick;
    logic   r_done;
    logic   r_err;

    state_t w_state_nxt;
    logic   w_load;
    logic   w_clear;
    logic   w_enable;
    logic   w_tick_nxt;
    logic   w_done_nxt;
    logic   w_err_nxt;
    logic   w_busy_nxt;
    logic   w_step;
    logic   w_term;

    count_seq_core #(
        .CNT_W (CNT_W),
        .PRE_W (PRE_W)
    ) u_core (
        .i_clk      (i_clk),
        .i_reset_n  (i_reset_n),
        .i_load     (w_load),
        .i_clear    (w_clear),
        .i_enable   (w_enable),
        .i_wrap     (i_periodic),
        .i_prescale (i_prescale),
        .i_limit    (i_limit),
        .o_count    (o_count),
        .o_step     (w_step),
        .o_term     (w_term)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_clear     = 1'b0;
        w_enable    = 1'b0;
        w_tick_nxt  = 1'b0;
        w_done_nxt  = 1'b0;
        w_err_nxt   = 1'b0;
        if (i_abort) begin
            w_state_nxt = IDLE;
            w_clear     = 1'b1;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (i_start) begin
                        if (i_limit != '0) begin
                            w_load      = 1'b1;
                            w_state_nxt = RUN;
                        end else begin
                            w_err_nxt = 1'b1;
                        end
                    end
                end
                // The resume edge out of PAUSE also advances, so a pause costs
                // exactly as many cycles as i_pause was sampled high.
                RUN, PAUSE: begin
                    if (i_pause) begin
                        w_state_nxt = PAUSE;
                    end else begin
                        w_state_nxt = RUN;
                        w_enable    = 1'b1;
                        if (w_step) begin
                            w_tick_nxt = 1'b1;
                            if (w_term) begin
                                w_done_nxt = 1'b1;
                                if (!i_periodic) begin
                                    w_state_nxt = DONE;
                                end
                            end
                        end
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    assign w_busy_nxt = (w_state_nxt == RUN) || (w_state_nxt == PAUSE);

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_tick  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= w_busy_nxt;
            r_tick  <= w_tick_nxt;
            r_done  <= w_done_nxt;
            r_err   <= w_err_nxt;
        end
    end

    assign o_busy  = r_busy;
    assign o_tick  = r_tick;
    assign o_done  = r_done;
    assign o_err   = r_err;
    assign o_state = r_state;

endmodule
